// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan display
// Holds the hex-to-segment table (active low, dp off), blank/dash codes and digit count.
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: display word in, scanned digit bus out
// data[32:1] value, data[0] valid; which = digit index; seg = active-low segments; frame_tick = snapshot pulse.
interface seg_scan_display_if;
  logic [32:0] data;
  logic [2:0] which;
  logic [7:0] seg;
  logic frame_tick;
  modport master (output data, input which, seg, frame_tick);
  modport slave (input data, output which, seg, frame_tick);
endinterface

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: 4-bit nibble to active-low 7-segment code
// Ports: nibble in, seg out (dp off).
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexes a 32-bit word as 8 hex digits on one 7-segment bus
// Ports: clk, Rst (async active-high), bus (slave: data in; which, seg, frame_tick out).
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits of a valid word.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int BLANK_CYC = 2
) (
  input logic clk,
  input logic Rst,
  seg_scan_display_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0] prescaler;
  logic [2:0] digit;
  logic [32:0] snap;
  logic [31:0] value;
  logic [3:0] nibble;
  logic [7:0] hex_seg, seg_next;
  logic slot_tick, frame_edge, lz_blank;
  assign slot_tick = prescaler == PW'(CLK_DIV - 1);
  assign frame_edge = slot_tick && digit == 3'd7;
  assign value = snap[32:1];
  assign nibble = value[{digit, 2'b00} +: 4];
  assign bus.which = digit;
  hex7seg_decode u_dec (.nibble(nibble), .seg(hex_seg));
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask, lz_next;
  // digit k is a leading zero when every nibble from k upward is zero; digit 0 always shows
  always_comb begin
    lz_next = '0;
    for (int k = 1; k < NUM_DIGITS; k++) lz_next[k] = (bus.data[32:1] >> (4 * k)) == 32'd0;
  end
  always_ff @(posedge clk or posedge Rst)
    if (Rst) lz_mask <= '0;
    else if (frame_edge) lz_mask <= lz_next;
  assign lz_blank = lz_mask[digit];
`else
  assign lz_blank = 1'b0;
`endif
  // blanking window first, then invalid dash, then leading-zero blank, then the digit
  assign seg_next = prescaler < PW'(BLANK_CYC) ? SEG_BLANK :
                    !snap[0] ? SEG_DASH :
                    lz_blank ? SEG_BLANK : hex_seg;
  always_ff @(posedge clk or posedge Rst)
    if (Rst) begin
      prescaler <= '0;
      digit <= '0;
      snap <= '0;
      bus.seg <= SEG_BLANK;
      bus.frame_tick <= 1'b0;
    end else begin
      prescaler <= slot_tick ? '0 : prescaler + 1'b1;
      digit <= digit + {2'b00, slot_tick};
      snap <= frame_edge ? bus.data : snap;
      bus.seg <= seg_next;
      bus.frame_tick <= frame_edge;
    end
endmodule
